// File: rtl/wb_fabric_initiator.sv
// -----------------------------------------------------------------------------
// wb_fabric_initiator
//
// Single-beat Wishbone initiator. It accepts one command at a time on a
// valid/ready interface, runs exactly one WBs_* bus cycle for it, and returns
// a response on a second valid/ready interface. When the responder does not
// acknowledge within TIMEOUT_CYCLES bus cycles, the cycle is aborted and an
// error response carrying DEFAULT_READ_VALUE is returned.
//
// Ports:
//   WB_CLK, WB_RST        clock; synchronous active-high reset
//   cmd_valid_i/ready_o   command handshake (accepted only in IDLE)
//   cmd_we_i, cmd_adr_i,  command: direction, byte address, byte enables,
//   cmd_byte_stb_i,       write data
//   cmd_wr_dat_i
//   rsp_valid_o/ready_i   response handshake
//   rsp_rd_dat_o          read data (0 for writes, DEFAULT_READ_VALUE on timeout)
//   rsp_err_o             1 = bus cycle timed out
//   busy_o                a command is in flight (state is not IDLE)
//   WBs_*                 registered Wishbone initiator signals
//   WBs_RD_DAT, WBs_ACK   responder data and acknowledge
// -----------------------------------------------------------------------------
module wb_fabric_initiator #(
    parameter int          APERWIDTH          = 17,
    parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC,
    parameter int          TIMEOUT_CNTR_WIDTH = 4,
    parameter int          TIMEOUT_CYCLES     = 15
) (
    input  logic                 WB_CLK,
    input  logic                 WB_RST,

    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [APERWIDTH-1:0] cmd_adr_i,
    input  logic [3:0]           cmd_byte_stb_i,
    input  logic [31:0]          cmd_wr_dat_i,

    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_rd_dat_o,
    output logic                 rsp_err_o,

    output logic                 busy_o,

    output logic [APERWIDTH-1:0] WBs_ADR,
    output logic                 WBs_CYC,
    output logic                 WBs_STB,
    output logic                 WBs_WE,
    output logic                 WBs_RD,
    output logic [3:0]           WBs_BYTE_STB,
    output logic [31:0]          WBs_WR_DAT,
    input  logic [31:0]          WBs_RD_DAT,
    input  logic                 WBs_ACK
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Counter value at which a still-unacknowledged cycle is aborted.
    localparam logic [TIMEOUT_CNTR_WIDTH-1:0] TIMEOUT_LAST =
        TIMEOUT_CNTR_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                        state_q,     state_d;
    logic [TIMEOUT_CNTR_WIDTH-1:0] cnt_q,       cnt_d;
    logic [APERWIDTH-1:0]          adr_q,       adr_d;
    logic                          cyc_q,       cyc_d;
    logic                          stb_q,       stb_d;
    logic                          we_q,        we_d;
    logic                          rd_q,        rd_d;
    logic [3:0]                    bstb_q,      bstb_d;
    logic [31:0]                   wdat_q,      wdat_d;
    logic                          rsp_valid_q, rsp_valid_d;
    logic [31:0]                   rsp_dat_q,   rsp_dat_d;
    logic                          rsp_err_q,   rsp_err_d;

    // Word alignment drops the two address LSBs.
    logic [1:0] unused_adr_lsb;
    assign unused_adr_lsb = cmd_adr_i[1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        adr_d       = adr_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        rd_d        = rd_q;
        bstb_d      = bstb_q;
        wdat_d      = wdat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = cmd_we_i;
                    rd_d    = ~cmd_we_i;
                    adr_d   = {cmd_adr_i[APERWIDTH-1:2], 2'b00};
                    bstb_d  = cmd_we_i ? cmd_byte_stb_i : 4'hF;
                    wdat_d  = cmd_we_i ? cmd_wr_dat_i : '0;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end

            BUS: begin
                // ACK is tested first so it wins over a coincident timeout.
                if (WBs_ACK || (cnt_q == TIMEOUT_LAST)) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rd_d        = 1'b0;
                    adr_d       = '0;
                    bstb_d      = '0;
                    wdat_d      = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                    if (WBs_ACK) begin
                        rsp_dat_d = we_q ? '0 : WBs_RD_DAT;
                        rsp_err_d = 1'b0;
                    end else begin
                        rsp_dat_d = DEFAULT_READ_VALUE;
                        rsp_err_d = 1'b1;
                    end
                end else begin
                    // Never reaches past TIMEOUT_LAST, so it cannot wrap.
                    cnt_d = cnt_q + TIMEOUT_CNTR_WIDTH'(1);
                end
            end

            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            adr_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            rd_q        <= 1'b0;
            bstb_q      <= '0;
            wdat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            adr_q       <= adr_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            rd_q        <= rd_d;
            bstb_q      <= bstb_d;
            wdat_q      <= wdat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready_o  = (state_q == IDLE) & ~WB_RST;
    assign busy_o       = (state_q != IDLE);

    assign WBs_ADR      = adr_q;
    assign WBs_CYC      = cyc_q;
    assign WBs_STB      = stb_q;
    assign WBs_WE       = we_q;
    assign WBs_RD       = rd_q;
    assign WBs_BYTE_STB = bstb_q;
    assign WBs_WR_DAT   = wdat_q;

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rd_dat_o = rsp_dat_q;
    assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_wb_fabric_initiator.sv
// -----------------------------------------------------------------------------
// tb_wb_fabric_initiator
//
// Self-checking bench for wb_fabric_initiator. Each transaction is described
// by its command and by the bus cycle on which the bench's responder
// acknowledges (0 = never). Expected bus fields, cycle length and response
// are derived from those numbers directly.
// -----------------------------------------------------------------------------
module tb_wb_fabric_initiator;

    localparam int          APERWIDTH   = 17;
    localparam logic [31:0] DEFAULT_RD  = 32'hBADFABAC;
    localparam int          TMO_CYCLES  = 15;

    logic        WB_CLK = 1'b0;
    logic        WB_RST = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [16:0] cmd_adr_i = '0;
    logic [3:0]  cmd_byte_stb_i = '0;
    logic [31:0] cmd_wr_dat_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rd_dat_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic [16:0] WBs_ADR;
    logic        WBs_CYC;
    logic        WBs_STB;
    logic        WBs_WE;
    logic        WBs_RD;
    logic [3:0]  WBs_BYTE_STB;
    logic [31:0] WBs_WR_DAT;
    logic [31:0] WBs_RD_DAT = '0;
    logic        WBs_ACK = 1'b0;

    int vectors    = 0;
    int miscompares = 0;
    logic ready_tied = 1'b0;

    always #5 WB_CLK = ~WB_CLK;

    wb_fabric_initiator #(
        .APERWIDTH         (APERWIDTH),
        .DEFAULT_READ_VALUE(32'hBAD_FAB_AC),
        .TIMEOUT_CNTR_WIDTH(4),
        .TIMEOUT_CYCLES    (TMO_CYCLES)
    ) dut (
        .WB_CLK        (WB_CLK),
        .WB_RST        (WB_RST),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_we_i      (cmd_we_i),
        .cmd_adr_i     (cmd_adr_i),
        .cmd_byte_stb_i(cmd_byte_stb_i),
        .cmd_wr_dat_i  (cmd_wr_dat_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rd_dat_o  (rsp_rd_dat_o),
        .rsp_err_o     (rsp_err_o),
        .busy_o        (busy_o),
        .WBs_ADR       (WBs_ADR),
        .WBs_CYC       (WBs_CYC),
        .WBs_STB       (WBs_STB),
        .WBs_WE        (WBs_WE),
        .WBs_RD        (WBs_RD),
        .WBs_BYTE_STB  (WBs_BYTE_STB),
        .WBs_WR_DAT    (WBs_WR_DAT),
        .WBs_RD_DAT    (WBs_RD_DAT),
        .WBs_ACK       (WBs_ACK)
    );

    // One complete command/response exchange. Starts and ends at a negedge
    // with the DUT idle. ack_at = bus cycle carrying ACK (0 = none);
    // hold = cycles rsp_ready_i stays low while a new command is offered.
    task automatic run_txn(input logic we, input logic [16:0] adr,
                           input logic [3:0] bstb, input logic [31:0] wdat,
                           input int ack_at, input logic [31:0] rdat,
                           input int hold, input string tag);
        int          cyc_cnt;
        int          exp_cycles;
        logic        exp_err;
        logic [31:0] exp_rdat;
        logic [55:0] exp_bus;
        logic [55:0] got_bus;
        logic [33:0] exp_rsp;
        logic [33:0] got_rsp;

        exp_err    = (ack_at < 1) || (ack_at > TMO_CYCLES);
        exp_cycles = exp_err ? TMO_CYCLES : ack_at;
        exp_rdat   = exp_err ? DEFAULT_RD : (we ? 32'h0 : rdat);
        exp_bus    = {adr[16:2], 2'b00, we, ~we, (we ? bstb : 4'hF),
                      (we ? wdat : 32'h0), 1'b1};
        exp_rsp    = {1'b1, exp_err, exp_rdat};

        vectors++;
        if (cmd_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s cmd_ready_idle: got %b want 1", tag, cmd_ready_o);
        end

        cmd_valid_i    = 1'b1;
        cmd_we_i       = we;
        cmd_adr_i      = adr;
        cmd_byte_stb_i = bstb;
        cmd_wr_dat_i   = wdat;
        @(negedge WB_CLK);
        // Junk on the command bus must not leak into the running cycle.
        cmd_valid_i    = 1'b0;
        cmd_we_i       = 1'($urandom);
        cmd_adr_i      = 17'($urandom);
        cmd_byte_stb_i = 4'($urandom);
        cmd_wr_dat_i   = $urandom;

        cyc_cnt = 0;
        while (WBs_CYC === 1'b1 && cyc_cnt < 40) begin
            cyc_cnt++;
            got_bus = {WBs_ADR, WBs_WE, WBs_RD, WBs_BYTE_STB, WBs_WR_DAT, WBs_STB};
            vectors++;
            if (got_bus !== exp_bus) begin
                miscompares++;
                $display("FAIL %s bus_fields cyc%0d: got %h want %h", tag, cyc_cnt, got_bus, exp_bus);
            end
            vectors++;
            if ({cmd_ready_o, rsp_valid_o, busy_o} !== 3'b001) begin
                miscompares++;
                $display("FAIL %s bus_status cyc%0d: got %b want 001", tag, cyc_cnt,
                         {cmd_ready_o, rsp_valid_o, busy_o});
            end
            WBs_ACK    = (cyc_cnt == ack_at);
            WBs_RD_DAT = WBs_ACK ? rdat : $urandom;
            @(negedge WB_CLK);
        end
        WBs_ACK    = 1'b0;
        WBs_RD_DAT = $urandom;

        vectors++;
        if (cyc_cnt != exp_cycles) begin
            miscompares++;
            $display("FAIL %s cyc_length: got %0d want %0d", tag, cyc_cnt, exp_cycles);
        end
        vectors++;
        if ({WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_ADR, WBs_BYTE_STB, WBs_WR_DAT} !== '0) begin
            miscompares++;
            $display("FAIL %s bus_cleared: got %h want 0", tag,
                     {WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_ADR, WBs_BYTE_STB, WBs_WR_DAT});
        end
        got_rsp = {rsp_valid_o, rsp_err_o, rsp_rd_dat_o};
        vectors++;
        if (got_rsp !== exp_rsp) begin
            miscompares++;
            $display("FAIL %s response: got %h want %h", tag, got_rsp, exp_rsp);
        end

        for (int i = 0; i < hold; i++) begin
            rsp_ready_i = 1'b0;
            cmd_valid_i = 1'b1;
            WBs_ACK     = 1'($urandom);
            WBs_RD_DAT  = $urandom;
            @(negedge WB_CLK);
            got_rsp = {rsp_valid_o, rsp_err_o, rsp_rd_dat_o};
            vectors++;
            if (got_rsp !== exp_rsp) begin
                miscompares++;
                $display("FAIL %s rsp_hold%0d: got %h want %h", tag, i, got_rsp, exp_rsp);
            end
            vectors++;
            if ({cmd_ready_o, busy_o, WBs_CYC} !== 3'b010) begin
                miscompares++;
                $display("FAIL %s hold_no_accept%0d: got %b want 010", tag, i,
                         {cmd_ready_o, busy_o, WBs_CYC});
            end
        end
        WBs_ACK     = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge WB_CLK);
        rsp_ready_i = ready_tied;
        vectors++;
        if ({rsp_valid_o, busy_o, cmd_ready_o, WBs_CYC} !== 4'b0010) begin
            miscompares++;
            $display("FAIL %s after_handshake: got %b want 0010", tag,
                     {rsp_valid_o, busy_o, cmd_ready_o, WBs_CYC});
        end
        cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        WB_RST = 1'b1;
        WBs_ACK = 1'b1;
        WBs_RD_DAT = 32'hFFFF_FFFF;
        repeat (3) @(negedge WB_CLK);
        vectors++;
        if ({cmd_ready_o, busy_o, rsp_valid_o, rsp_err_o, rsp_rd_dat_o, WBs_CYC, WBs_STB,
             WBs_WE, WBs_RD, WBs_ADR, WBs_BYTE_STB, WBs_WR_DAT} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0",
                     {cmd_ready_o, busy_o, rsp_valid_o, rsp_err_o, rsp_rd_dat_o, WBs_CYC, WBs_STB,
                      WBs_WE, WBs_RD, WBs_ADR, WBs_BYTE_STB, WBs_WR_DAT});
        end
        WBs_ACK = 1'b0;
        WB_RST  = 1'b0;
        @(negedge WB_CLK);
        vectors++;
        if ({cmd_ready_o, busy_o, rsp_valid_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_release: got %b want 100", {cmd_ready_o, busy_o, rsp_valid_o});
        end
    endtask

    task automatic test_write();
        run_txn(1'b1, 17'h01004, 4'h1, 32'h0000_00A5, 1, $urandom, 0, "write");
    endtask

    task automatic test_read_wait();
        run_txn(1'b0, 17'h01003, 4'h0, 32'h0, 3, 32'h1234_5678, 0, "read_wait");
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 17'h00208, 4'h0, 32'h0, 0, 32'h0, 0, "timeout");
    endtask

    task automatic test_ack_boundary();
        run_txn(1'b0, 17'h1FFFF, 4'h0, 32'h0, TMO_CYCLES, 32'hCAFE_F00D, 5, "ack_boundary");
    endtask

    task automatic test_stray_ack();
        for (int i = 0; i < 3; i++) begin
            WBs_ACK    = 1'b1;
            WBs_RD_DAT = $urandom;
            @(negedge WB_CLK);
            vectors++;
            if ({rsp_valid_o, busy_o, WBs_CYC, cmd_ready_o} !== 4'b0001) begin
                miscompares++;
                $display("FAIL stray_ack%0d: got %b want 0001", i,
                         {rsp_valid_o, busy_o, WBs_CYC, cmd_ready_o});
            end
        end
        WBs_ACK = 1'b0;
    endtask

    task automatic test_back_to_back();
        ready_tied  = 1'b1;
        rsp_ready_i = 1'b1;
        run_txn(1'b1, 17'h00010, 4'hC, 32'hDEAD_BEEF, 2, 32'h0, 0, "b2b_first");
        run_txn(1'b0, 17'h00014, 4'h0, 32'h0, 1, 32'h5555_AAAA, 0, "b2b_second");
        ready_tied  = 1'b0;
        rsp_ready_i = 1'b0;
        test_stray_ack();
    endtask

    task automatic test_reset_mid();
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 17'h00400;
        @(negedge WB_CLK);
        cmd_valid_i = 1'b0;
        @(negedge WB_CLK);
        vectors++;
        if (WBs_CYC !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_in_bus: got %b want 1", WBs_CYC);
        end
        WB_RST = 1'b1;
        @(negedge WB_CLK);
        vectors++;
        if ({WBs_CYC, WBs_STB, rsp_valid_o, busy_o, cmd_ready_o} !== 5'b0) begin
            miscompares++;
            $display("FAIL rst_mid_abort: got %b want 00000",
                     {WBs_CYC, WBs_STB, rsp_valid_o, busy_o, cmd_ready_o});
        end
        WB_RST = 1'b0;
        @(negedge WB_CLK);
        vectors++;
        if ({cmd_ready_o, rsp_valid_o, WBs_CYC} !== 3'b100) begin
            miscompares++;
            $display("FAIL rst_mid_release: got %b want 100", {cmd_ready_o, rsp_valid_o, WBs_CYC});
        end
        run_txn(1'b0, 17'h00404, 4'h0, 32'h0, 2, 32'h0BAD_CAFE, 0, "rst_mid_fresh");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            run_txn(1'($urandom), 17'($urandom), 4'($urandom), $urandom,
                    int'($urandom_range(0, 18)), $urandom, int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_timeout();
        test_ack_boundary();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_fabric_initiator.md
Name: wb_fabric_initiator

Overview:
- Wishbone initiator (master) that generates single-beat WBs_* cycles toward a fabric Wishbone responder such as the UART/register aperture.
- Used as the in-fabric and testbench driver for the same bus the AHB-to-FPGA bridge drives.
- Accepts one command at a time on a valid/ready interface and runs exactly one bus cycle per command.
- Returns read data, or an error response if WBs_ACK does not arrive within a bounded number of cycles.

Parameters:
- APERWIDTH, 17, width of WBs_ADR and cmd_adr_i.
- DEFAULT_READ_VALUE, 32'hBAD_FAB_AC, data returned on timeout.
- TIMEOUT_CNTR_WIDTH, 4, width of the wait-cycle counter.
- TIMEOUT_CYCLES, 15, maximum bus cycles without ACK before abort; must be less than 2**TIMEOUT_CNTR_WIDTH.

Ports:
- WB_CLK  in  1  sole clock; everything is sampled on the rising edge.
- WB_RST  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when cmd_valid_i and cmd_ready_o are both high at an edge.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  APERWIDTH  byte address.
- cmd_byte_stb_i  in  4  byte enables for a write.
- cmd_wr_dat_i  in  32  write data.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when rsp_valid_o and rsp_ready_i are both high at an edge.
- rsp_rd_dat_o  out  32  read data.
- rsp_err_o  out  1  1 = timeout.
- busy_o  out  1  state is not IDLE.
- WBs_ADR  out  APERWIDTH  bus address.
- WBs_CYC  out  1  cycle.
- WBs_STB  out  1  strobe.
- WBs_WE  out  1  write enable.
- WBs_RD  out  1  read enable.
- WBs_BYTE_STB  out  4  byte strobes.
- WBs_WR_DAT  out  32  write data.
- WBs_RD_DAT  in  32  read data from the responder.
- WBs_ACK  in  1  acknowledge from the responder.

Behaviour:
- Clocking and reset: one clock (WB_CLK); reset is synchronous and active-high (WB_RST).
- Reset state:
  - State goes to IDLE.
  - All WBs_* outputs, rsp_valid_o, rsp_err_o, rsp_rd_dat_o and busy_o are 0.
  - cmd_ready_o = (state==IDLE) & ~WB_RST, so it is 0 while WB_RST is high.
- FSM states: IDLE, BUS, RESP. All bus and response outputs are registered.
- IDLE:
  - cmd_ready_o = 1.
  - On accept, latch the command.
  - At the same edge, drive WBs_CYC=WBs_STB=1, WBs_WE=cmd_we_i, WBs_RD=~cmd_we_i.
  - WBs_ADR = {cmd_adr_i[APERWIDTH-1:2], 2'b00}.
  - WBs_BYTE_STB = cmd_byte_stb_i for a write, 4'hF for a read.
  - WBs_WR_DAT = cmd_wr_dat_i for a write, 0 for a read.
  - Clear the wait counter and go to BUS.
- BUS:
  - cmd_ready_o = 0; all WBs_* outputs are held stable.
  - WBs_ACK=1 at an edge:
    - Clear CYC, STB, WE, RD, ADR, BYTE_STB and WR_DAT at that edge.
    - rsp_rd_dat_o = WBs_RD_DAT for a read, 32'h0 for a write.
    - rsp_err_o = 0; rsp_valid_o = 1; go to RESP.
  - No ACK and counter == TIMEOUT_CYCLES-1:
    - Abort: clear the WBs_* outputs identically.
    - rsp_rd_dat_o = DEFAULT_READ_VALUE, rsp_err_o = 1, rsp_valid_o = 1; go to RESP.
  - Otherwise the counter increments. The counter must not wrap.
  - ACK in the same cycle as the timeout condition: ACK wins and the response is normal.
- RESP:
  - rsp_valid_o, rsp_rd_dat_o and rsp_err_o are held until rsp_ready_i.
  - On handshake: rsp_valid_o = 0, go to IDLE.
  - A new command can be accepted on the cycle after the response handshake, never on the same cycle.
- Latency:
  - Command accepted at edge N → WBs_CYC high from N.
  - First ACK sampled at edge N+1 gives rsp_valid_o high after N+1.
  - Minimum command-to-response is 2 edges.
  - A timeout gives CYC high for exactly TIMEOUT_CYCLES cycles.
- Stray inputs: WBs_ACK in IDLE or RESP is ignored; WBs_RD_DAT is sampled only on the ACK edge.
- Reset mid-operation: WB_RST in BUS or RESP aborts. Bus outputs and response go to 0 at that edge and no response is produced.
- cmd_* inputs are not sampled outside IDLE accept.

Test Plan:
- Write: cmd we=1, adr=17'h01004, stb=4'h1, dat=32'h000000A5; responder ACKs on its 1st cycle → WBs_ADR=17'h01004, WE=1, RD=0, BYTE_STB=1, CYC high 1 cycle; rsp_valid with err=0, rd_dat=0.
- Read with wait states: read adr=17'h01003; ACK on the 3rd bus cycle with RD_DAT=32'h12345678 → WBs_ADR=17'h01000, BYTE_STB=F, CYC high 3 cycles; rsp rd_dat=32'h12345678, err=0.
- Timeout: read, ACK never asserted → CYC high exactly 15 cycles; rsp rd_dat=32'hBAD_FAB_AC, err=1.
- Boundary: ACK arrives on the 15th bus cycle → err=0 with real data; then rsp_ready_i held low 5 cycles → response held stable, cmd_ready_o=0, a new cmd_valid_i is not accepted.
- Back-to-back: two queued commands with rsp_ready_i tied high → second CYC begins exactly 1 cycle after the first response handshake; stray ACK in IDLE produces no response.
- Reset mid-cycle: assert WB_RST in BUS cycle 2 → next edge CYC=STB=0, rsp_valid_o=0; after release, cmd_ready_o=1 and a fresh read completes normally.
